// File: rtl/pblaze_io_responder.sv
// Port-bus responder for the kcpsm6 core: GPIO pair, reloadable interval timer,
// 4-deep receive FIFO and a level interrupt held until the core acknowledges it.
module pblaze_io_responder #(
    parameter logic [7:0] BASE_ADDR = 8'h00,
    parameter int         TIMER_W   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    input  logic       k_write_strobe,
    input  logic       read_strobe,
    output logic [7:0] in_port,
    output logic       interrupt,
    input  logic       interrupt_ack,
    input  logic [7:0] gpio_in,
    output logic [7:0] gpio_out,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready
);

    logic [7:0]         in_port_q, in_port_d;
    logic [7:0]         gpio_out_q, gpio_out_d;
    logic [7:0]         sync1_q, sync2_q;
    logic [TIMER_W-1:0] reload_q, reload_d;
    logic [TIMER_W-1:0] counter_q, counter_d;
    logic [2:0]         ctrl_q, ctrl_d;
    logic               timer_flag_q, timer_flag_d;
    logic               interrupt_q, interrupt_d;
    logic [7:0]         mem_q [4];
    logic [7:0]         mem_d [4];
    logic [1:0]         wr_ptr_q, wr_ptr_d;
    logic [1:0]         rd_ptr_q, rd_ptr_d;
    logic [2:0]         count_q, count_d;

    logic       sel, wr_en, fifo_empty, fifo_full, push, pop, flag_set, flag_clr, tmr_start;
    logic [3:0] addr;

    assign addr       = port_id[3:0];
    assign sel        = (port_id[7:4] == BASE_ADDR[7:4]);
    // OUTPUTK carries only a 4-bit port, so it skips the base match.
    assign wr_en      = (write_strobe & sel) | k_write_strobe;
    assign fifo_empty = (count_q == 3'd0);
    assign fifo_full  = (count_q == 3'd4);
    assign push       = rx_valid & ~fifo_full;
    assign pop        = read_strobe & sel & (addr == 4'h5) & ~fifo_empty;
    assign flag_clr   = wr_en & (addr == 4'h4) & out_port[0];
    assign tmr_start  = wr_en & (addr == 4'h3) & out_port[0] & ~ctrl_q[0];

    always_comb begin
        gpio_out_d = gpio_out_q;
        reload_d   = reload_q;
        ctrl_d     = ctrl_q;
        if (wr_en) begin
            case (addr)
                4'h0:    gpio_out_d = out_port;
                4'h1:    reload_d[7:0] = out_port;
                4'h2:    reload_d[15:8] = out_port;
                4'h3:    ctrl_d = out_port[2:0];
                default: ;
            endcase
        end
    end

    // A reload written mid-run is only picked up at the next wrap.
    always_comb begin
        counter_d    = counter_q;
        flag_set     = 1'b0;
        if (tmr_start) begin
            counter_d = reload_q;
        end else if (ctrl_q[0]) begin
            if (counter_q == '0) begin
                counter_d = reload_q;
                flag_set  = 1'b1;
            end else begin
                counter_d = counter_q - TIMER_W'(1);
            end
        end
        timer_flag_d = timer_flag_q;
        if (flag_set)
            timer_flag_d = 1'b1;
        else if (flag_clr)
            timer_flag_d = 1'b0;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = rx_data;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + 2'd1;
        if (push && !pop)
            count_d = count_q + 3'd1;
        else if (pop && !push)
            count_d = count_q - 3'd1;
    end

    always_comb begin
        in_port_d = 8'h00;
        if (sel) begin
            case (addr)
                4'h0:    in_port_d = sync2_q;
                4'h1:    in_port_d = reload_q[7:0];
                4'h2:    in_port_d = reload_q[15:8];
                4'h3:    in_port_d = {5'b0, ctrl_q};
                4'h4:    in_port_d = {2'b0, count_q, fifo_full, ~fifo_empty, timer_flag_q};
                4'h5:    in_port_d = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
                default: in_port_d = 8'h00;
            endcase
        end
    end

    // Acknowledge beats a new request; the source must be cleared to stop re-raising.
    always_comb begin
        interrupt_d = interrupt_q;
        if (interrupt_q && interrupt_ack)
            interrupt_d = 1'b0;
        else if (!interrupt_q && ((timer_flag_q & ctrl_q[1]) | (~fifo_empty & ctrl_q[2])))
            interrupt_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_port_q    <= 8'h00;
            gpio_out_q   <= 8'h00;
            sync1_q      <= 8'h00;
            sync2_q      <= 8'h00;
            reload_q     <= '1;
            counter_q    <= '1;
            ctrl_q       <= 3'b000;
            timer_flag_q <= 1'b0;
            interrupt_q  <= 1'b0;
            for (int i = 0; i < 4; i++) mem_q[i] <= 8'h00;
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            count_q      <= 3'd0;
        end else begin
            in_port_q    <= in_port_d;
            gpio_out_q   <= gpio_out_d;
            sync1_q      <= gpio_in;
            sync2_q      <= sync1_q;
            reload_q     <= reload_d;
            counter_q    <= counter_d;
            ctrl_q       <= ctrl_d;
            timer_flag_q <= timer_flag_d;
            interrupt_q  <= interrupt_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    assign in_port   = in_port_q;
    assign gpio_out  = gpio_out_q;
    assign interrupt = interrupt_q;
    assign rx_ready  = ~fifo_full;

endmodule

// File: tb/tb_pblaze_io_responder.sv
// Directed bench for pblaze_io_responder: one instance at base 0x00, one at base 0x20.
module tb_pblaze_io_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] port_id = 8'h00;
    logic [7:0] out_port = 8'h00;
    logic       write_strobe = 1'b0;
    logic       k_write_strobe = 1'b0;
    logic       read_strobe = 1'b0;
    logic       interrupt_ack = 1'b0;
    logic [7:0] gpio_in = 8'h00;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;

    logic [7:0] in_port, gpio_out;
    logic       interrupt, rx_ready;
    logic [7:0] in_port_b, gpio_out_b;
    logic       interrupt_b, rx_ready_b;

    int compared = 0;
    int mismatched = 0;
    logic [7:0] rd;

    always #5 clk = ~clk;

    pblaze_io_responder #(.BASE_ADDR(8'h00), .TIMER_W(16)) dut (
        .clk(clk), .rst(rst), .port_id(port_id), .out_port(out_port),
        .write_strobe(write_strobe), .k_write_strobe(k_write_strobe),
        .read_strobe(read_strobe), .in_port(in_port), .interrupt(interrupt),
        .interrupt_ack(interrupt_ack), .gpio_in(gpio_in), .gpio_out(gpio_out),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    pblaze_io_responder #(.BASE_ADDR(8'h20), .TIMER_W(16)) dut_b (
        .clk(clk), .rst(rst), .port_id(port_id), .out_port(out_port),
        .write_strobe(write_strobe), .k_write_strobe(k_write_strobe),
        .read_strobe(read_strobe), .in_port(in_port_b), .interrupt(interrupt_b),
        .interrupt_ack(interrupt_ack), .gpio_in(gpio_in), .gpio_out(gpio_out_b),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready_b)
    );

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind 0 = OUTPUT, 1 = OUTPUTK
    task automatic applyStimulus(input logic [7:0] port, input logic [7:0] data, input bit kind);
        port_id  = port;
        out_port = data;
        if (kind) k_write_strobe = 1'b1;
        else      write_strobe   = 1'b1;
        tick();
        write_strobe   = 1'b0;
        k_write_strobe = 1'b0;
    endtask

    task automatic readPort(input logic [7:0] port, input bit strobe, output logic [7:0] data);
        port_id     = port;
        read_strobe = strobe;
        tick();
        read_strobe = 1'b0;
        data        = in_port;
    endtask

    task automatic pushByte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    initial begin
        tick();
        checkOutput("reset in_port", in_port, 8'h00);
        checkOutput("reset gpio_out", gpio_out, 8'h00);
        checkOutput("reset interrupt", {7'b0, interrupt}, 8'h00);
        checkOutput("reset rx_ready", {7'b0, rx_ready}, 8'h01);
        rst = 1'b1;
        tick();

        applyStimulus(8'h00, 8'hA5, 1'b0);
        checkOutput("gpio OUTPUT", gpio_out, 8'hA5);
        checkOutput("base20 ignores 0x00", gpio_out_b, 8'h00);
        applyStimulus(8'h20, 8'h77, 1'b0);
        checkOutput("base20 OUTPUT 0x20", gpio_out_b, 8'h77);
        checkOutput("base00 ignores 0x20", gpio_out, 8'hA5);
        applyStimulus(8'h50, 8'h3C, 1'b1);
        checkOutput("gpio OUTPUTK", gpio_out, 8'h3C);
        checkOutput("base20 OUTPUTK", gpio_out_b, 8'h3C);

        gpio_in = 8'h5A;
        tick();
        tick();
        readPort(8'h00, 1'b1, rd);
        checkOutput("gpio_in sync read", rd, 8'h5A);
        readPort(8'h07, 1'b1, rd);
        checkOutput("unmapped port 7", rd, 8'h00);

        applyStimulus(8'h01, 8'h04, 1'b0);
        applyStimulus(8'h02, 8'h00, 1'b0);
        readPort(8'h01, 1'b1, rd);
        checkOutput("reload lo readback", rd, 8'h04);
        readPort(8'h02, 1'b1, rd);
        checkOutput("reload hi readback", rd, 8'h00);

        // Enable edge loads counter=4; flag at +5 edges, interrupt one edge later.
        applyStimulus(8'h03, 8'h03, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("irq before wrap", {7'b0, interrupt}, 8'h00);
        tick();
        checkOutput("irq same edge as flag", {7'b0, interrupt}, 8'h00);
        tick();
        checkOutput("irq after flag", {7'b0, interrupt}, 8'h01);
        readPort(8'h04, 1'b1, rd);
        checkOutput("status flag set", rd, 8'h01);
        applyStimulus(8'h03, 8'h02, 1'b0);
        applyStimulus(8'h04, 8'h01, 1'b0);
        checkOutput("irq held until ack", {7'b0, interrupt}, 8'h01);
        readPort(8'h04, 1'b1, rd);
        checkOutput("status flag cleared", rd, 8'h00);
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        checkOutput("irq cleared by ack", {7'b0, interrupt}, 8'h00);
        for (int i = 0; i < 8; i++) tick();
        checkOutput("irq stays low", {7'b0, interrupt}, 8'h00);
        readPort(8'h04, 1'b1, rd);
        checkOutput("timer frozen", rd, 8'h00);

        pushByte(8'h11);
        pushByte(8'h22);
        pushByte(8'h33);
        pushByte(8'h44);
        checkOutput("rx_ready full", {7'b0, rx_ready}, 8'h00);
        readPort(8'h04, 1'b1, rd);
        checkOutput("status full", rd, 8'h26);
        pushByte(8'h55);
        readPort(8'h05, 1'b1, rd);
        checkOutput("pop 1", rd, 8'h11);
        readPort(8'h05, 1'b1, rd);
        checkOutput("pop 2", rd, 8'h22);
        readPort(8'h05, 1'b1, rd);
        checkOutput("pop 3", rd, 8'h33);
        readPort(8'h05, 1'b1, rd);
        checkOutput("pop 4", rd, 8'h44);
        readPort(8'h05, 1'b1, rd);
        checkOutput("pop empty", rd, 8'h00);
        readPort(8'h04, 1'b1, rd);
        checkOutput("status empty", rd, 8'h00);

        pushByte(8'hAA);
        pushByte(8'hBB);
        rx_data  = 8'hCC;
        rx_valid = 1'b1;
        readPort(8'h05, 1'b1, rd);
        rx_valid = 1'b0;
        checkOutput("push+pop head", rd, 8'hAA);
        readPort(8'h04, 1'b1, rd);
        checkOutput("push+pop count 2", rd, 8'h12);
        readPort(8'h05, 1'b1, rd);
        checkOutput("order after push+pop a", rd, 8'hBB);
        readPort(8'h05, 1'b1, rd);
        checkOutput("order after push+pop b", rd, 8'hCC);

        rx_data  = 8'hDD;
        rx_valid = 1'b1;
        readPort(8'h05, 1'b1, rd);
        rx_valid = 1'b0;
        checkOutput("empty push+pop read", rd, 8'h00);
        readPort(8'h04, 1'b1, rd);
        checkOutput("empty push+pop count 1", rd, 8'h0A);

        applyStimulus(8'h03, 8'h04, 1'b0);
        tick();
        checkOutput("rx irq", {7'b0, interrupt}, 8'h01);
        pushByte(8'hEE);
        pushByte(8'hFF);
        pushByte(8'h01);
        checkOutput("rx_ready before reset", {7'b0, rx_ready}, 8'h00);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("async reset irq", {7'b0, interrupt}, 8'h00);
        checkOutput("async reset rx_ready", {7'b0, rx_ready}, 8'h01);
        checkOutput("async reset in_port", in_port, 8'h00);
        checkOutput("async reset gpio_out", gpio_out, 8'h00);
        tick();
        rst = 1'b1;
        readPort(8'h04, 1'b1, rd);
        checkOutput("status after reset", rd, 8'h00);
        readPort(8'h03, 1'b1, rd);
        checkOutput("ctrl after reset", rd, 8'h00);
        readPort(8'h01, 1'b1, rd);
        checkOutput("reload after reset", rd, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pblaze_io_responder.md
Name: pblaze_io_responder

Overview:
Port-bus responder for the kcpsm6 core. It decodes port_id together with write_strobe, k_write_strobe and read_strobe, holds the peripheral registers, and drives in_port back to the core. It contains a GPIO register pair, a reloadable interval timer and a 4-deep receive byte FIFO fed by an external producer. It raises interrupt and holds it until interrupt_ack, which matches the core's interrupt handshake.

Parameters:
BASE_ADDR, 8'h00, only bits [7:4] are used; the block responds to port_id[7:4] == BASE_ADDR[7:4] for INPUT and OUTPUT.
TIMER_W, 16, timer counter/reload width; fixed at 16 by the 2-byte register map.

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  asynchronous, active-low reset
port_id  input  8  port address from core
out_port  input  8  write data from core
write_strobe  input  1  OUTPUT strobe, 1 cycle
k_write_strobe  input  1  OUTPUTK strobe, 1 cycle; decodes port_id[3:0] only
read_strobe  input  1  INPUT strobe, 1 cycle
in_port  output  8  registered read data to core
interrupt  output  1  interrupt request to core
interrupt_ack  input  1  interrupt acknowledge from core
gpio_in  input  8  asynchronous external inputs
gpio_out  output  8  general-purpose output register
rx_data  input  8  producer byte
rx_valid  input  1  producer byte valid
rx_ready  output  1  FIFO can accept (= not full)

Behaviour:
Reset (rst=0, asynchronous):
- in_port=0, gpio_out=0, interrupt=0.
- Control=0, reload=16'hFFFF, counter=16'hFFFF, timer_flag=0.
- FIFO empty, so rx_ready=1.
- gpio_in 2-FF synchronizer cleared.

Register map (low nibble; sel = base match):
- 0x0: W gpio_out. R synchronized gpio_in.
- 0x1: W reload[7:0]. R reload[7:0].
- 0x2: W reload[15:8]. R reload[15:8].
- 0x3: W/R ctrl: bit0 tmr_en, bit1 tmr_ie, bit2 rx_ie; bits[7:3] read 0.
- 0x4: R status: bit0 timer_flag, bit1 rx_ne, bit2 rx_full, bits[5:3] rx_count (0-4), bits[7:6] 0. W: writing 1 to bit0 clears timer_flag; other bits ignored.
- 0x5: R FIFO head (pop). Reads 0x00 when empty.
- 0x6-0xF, or no base match: R 0x00; W ignored.

Write path:
- write_strobe & sel: write registers 0x0-0x4.
- k_write_strobe: same decode on port_id[3:0], with no base match.

Read path:
- in_port <= mux(port_id) every cycle; 1-cycle latency. in_port is valid before read_strobe because port_id is stable for 2 cycles.
- read_strobe & sel & port 0x5 & not empty: pop after the strobe edge.
- read_strobe on an empty FIFO: no pop, no error.

Timer:
- tmr_en 0->1 write loads counter from reload.
- While tmr_en=1, counter decrements each clk. At counter==0: timer_flag<=1 and counter<=reload, giving period reload+1 cycles.
- Reload written while running takes effect at the next wrap.
- tmr_en=0 freezes counter.
- Clear-write and flag-set in the same cycle: set wins.

FIFO:
- 4 entries, 2-bit pointers that wrap, 3-bit count.
- Push when rx_valid & rx_ready. rx_ready = count<4, combinational from count.
- Push and pop in the same cycle with 0<count<4: both occur, count unchanged.
- Push and pop in the same cycle with count==0: push only; the pop is suppressed because head is invalid.

Interrupt:
- cond = (timer_flag & tmr_ie) | (rx_ne & rx_ie).
- interrupt <= 1 when cond & ~interrupt.
- Held until interrupt_ack=1, then cleared next edge; ack has priority over set in that cycle.
- May reassert from the following cycle if cond is still true; the ISR must clear the source.
- interrupt_ack with interrupt=0: ignored.

Reset mid-operation: immediate return to reset values, FIFO contents discarded.

Test Plan:
- Reset, then OUTPUT 0xA5 to port 0x00; OUTPUTK 0x3C to 0x0 -> gpio_out=0xA5 then 0x3C. gpio_in=0x5A -> INPUT port 0x00 returns 0x5A (after 2-cycle sync). INPUT port 0x07 returns 0x00.
- Reload=0x0004, ctrl=0x03 -> timer_flag sets every 5 cycles; interrupt rises 1 cycle after flag and stays high until interrupt_ack pulse. Write 0x01 to port 0x04 -> flag clears; interrupt does not reassert.
- Push 0x11,0x22,0x33,0x44 -> rx_ready=0, status=0x26 (ne, full, count 4). A 5th rx_valid is not accepted. INPUT 0x05 x4 returns 0x11,0x22,0x33,0x44 in order. A 5th INPUT returns 0x00, count stays 0.
- FIFO at count 2, rx_valid during read_strobe on 0x05 -> count stays 2, order preserved.
- BASE_ADDR=8'h20: OUTPUT to port 0x00 ignored; OUTPUT to 0x20 writes gpio_out; OUTPUTK to 0x0 writes gpio_out.
- rx_ie=1 with FIFO non-empty, assert rst low mid-burst -> interrupt=0, FIFO empty and rx_ready=1 immediately, without waiting for a clock edge.
